// File: rtl/round_sequencer_pkg.sv
// Shared state/winner encodings and score helpers for the round sequencer.
package round_seq_pkg;

  typedef enum logic [2:0] {
    RST_RND    = 3'd0,
    COUNTDOWN  = 3'd1,
    FIGHT      = 3'd2,
    KO         = 3'd3,
    MATCH_OVER = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } win_e;

  localparam logic [1:0] SCORE_MAX = 2'd3;

  function automatic logic [1:0] sat_inc(input logic [1:0] s, input logic en);
    return (en && (s != SCORE_MAX)) ? s + 2'd1 : s;
  endfunction

endpackage

// File: rtl/round_sequencer_hold_timer.sv
// Counts consecutive tick samples of `level` high; `fire` pulses on the
// HOLD_TICKS-th one (same cycle as that tick) and the count restarts.
module hold_timer #(
  parameter int HOLD_TICKS = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic level,
  output logic fire
);

  localparam int CW = $clog2(HOLD_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD_TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    fire  = 1'b0;
    if (tick) begin
      if (!level) begin
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        cnt_d = '0;
        fire  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/round_sequencer.sv
// Round lifecycle: reset pulse, 3-2-1 countdown, fight, KO scoring, best-of-N match, hold-to-restart.
// Advances only on `tick`; ROUND_SEQ_TIMEOUT_EN adds a fight time limit decided on health.
module round_sequencer
  import round_seq_pkg::*;
#(
  parameter int COUNT_TICKS   = 20,
  parameter int KO_TICKS      = 40,
  parameter int HOLD_TICKS    = 40,
  parameter int ROUNDS_TO_WIN = 2,
  parameter int TIME_LIMIT    = 1980
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] winner,
  input  logic [8:0] health_1,
  input  logic [8:0] health_2,
  input  logic       restart_btn,
  input  logic       force_rst,
  output logic       game_rst,
  output logic       play_en,
  output logic [2:0] state,
  output logic [1:0] countdown,
  output logic [1:0] p1_rounds,
  output logic [1:0] p2_rounds,
  output logic [1:0] match_winner,
  output logic       timed_out
);

  localparam int CMAX = (COUNT_TICKS > KO_TICKS) ? COUNT_TICKS : KO_TICKS;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(COUNT_TICKS - 1);
  localparam logic [CW-1:0] KO_LAST    = CW'(KO_TICKS - 1);
  localparam logic [1:0]    R_WIN      = 2'(ROUNDS_TO_WIN);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [1:0]    p1_q, p1_d, p2_q, p2_d;
  logic [1:0]    mw_q, mw_d;

  logic       restart_fire, force_fire, restart;
  logic       timeout_hit;
  logic [1:0] to_win;
  logic [1:0] round_code;
  logic       round_end;
  logic       p1_reach, p2_reach;

  // restart_btn doubles as attack, so its hold only counts in MATCH_OVER
  hold_timer #(.HOLD_TICKS(HOLD_TICKS)) u_restart_hold (
    .clk(clk), .reset(reset), .tick(tick),
    .level(restart_btn && (state_q == MATCH_OVER)), .fire(restart_fire)
  );

  hold_timer #(.HOLD_TICKS(HOLD_TICKS)) u_force_hold (
    .clk(clk), .reset(reset), .tick(tick),
    .level(force_rst), .fire(force_fire)
  );

  assign restart = restart_fire || force_fire;

`ifdef ROUND_SEQ_TIMEOUT_EN
  localparam int FW = $clog2(TIME_LIMIT + 1);
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          to_q, to_d;

  assign timeout_hit = (state_q == FIGHT) && (fcnt_q == FW'(TIME_LIMIT - 1));
  assign to_win      = (health_1 > health_2) ? WIN_P1 :
                       (health_2 > health_1) ? WIN_P2 : WIN_DRAW;

  always_comb begin
    fcnt_d = fcnt_q;
    to_d   = to_q;
    if (tick) begin
      fcnt_d = (state_q == FIGHT) ? fcnt_q + FW'(1) : '0;
      if (restart)        to_d = 1'b0;
      else if (round_end) to_d = (winner == WIN_NONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fcnt_q <= '0;
      to_q   <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      to_q   <= to_d;
    end
  end

  assign timed_out = to_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^{health_1, health_2, TIME_LIMIT[0]};
  assign timeout_hit    = 1'b0;
  assign to_win         = WIN_NONE;
  assign timed_out      = 1'b0;
`endif

  // a real winner code on the limit tick takes priority over the health decision
  assign round_code = ((winner == WIN_NONE) && timeout_hit) ? to_win : winner;
  assign round_end  = (state_q == FIGHT) && (round_code != WIN_NONE);
  assign p1_reach   = (p1_q >= R_WIN);
  assign p2_reach   = (p2_q >= R_WIN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    mw_d    = mw_q;
    if (tick) begin
      if (restart) begin
        state_d = RST_RND;
        cnt_d   = '0;
        digit_d = 2'd0;
        p1_d    = 2'd0;
        p2_d    = 2'd0;
        mw_d    = WIN_NONE;
      end else begin
        case (state_q)
          RST_RND: begin
            state_d = COUNTDOWN;
            digit_d = 2'd3;
            cnt_d   = '0;
          end
          COUNTDOWN: begin
            if (cnt_q == COUNT_LAST) begin
              cnt_d   = '0;
              digit_d = digit_q - 2'd1;
              if (digit_q == 2'd1) state_d = FIGHT;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          FIGHT: begin
            if (round_end) begin
              state_d = KO;
              cnt_d   = '0;
              // bit0 set for P1 or draw, bit1 for P2 or draw
              p1_d    = sat_inc(p1_q, round_code[0]);
              p2_d    = sat_inc(p2_q, round_code[1]);
            end
          end
          KO: begin
            if (cnt_q == KO_LAST) begin
              cnt_d = '0;
              if (p1_reach || p2_reach) begin
                state_d = MATCH_OVER;
                mw_d    = {p2_reach, p1_reach};
              end else begin
                state_d = RST_RND;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          MATCH_OVER: ;
          default: state_d = RST_RND;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RST_RND;
      cnt_q   <= '0;
      digit_q <= 2'd0;
      p1_q    <= 2'd0;
      p2_q    <= 2'd0;
      mw_q    <= WIN_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      mw_q    <= mw_d;
    end
  end

  assign state        = state_q;
  assign game_rst     = (state_q == RST_RND);
  assign play_en      = (state_q == FIGHT);
  assign countdown    = digit_q;
  assign p1_rounds    = p1_q;
  assign p2_rounds    = p2_q;
  assign match_winner = mw_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Scenario bench for round_sequencer: KO scores come from a queue filled when the winner is driven.
module tb_round_sequencer;
  import round_seq_pkg::*;

`ifdef ROUND_SEQ_TIMEOUT_EN
  localparam int TL = 10;
`else
  localparam int TL = 1980;
`endif

  logic       clk = 1'b0, reset = 1'b0, tick = 1'b0;
  logic       restart_btn = 1'b0, force_rst = 1'b0;
  logic [1:0] winner = 2'b00;
  logic [8:0] health_1 = 9'd100, health_2 = 9'd80;
  logic       game_rst, play_en, timed_out;
  logic [2:0] state;
  logic [1:0] countdown, p1_rounds, p2_rounds, match_winner;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] p1;
    logic [1:0] p2;
    logic       to;
  } ko_exp_t;
  ko_exp_t sb[$];
  ko_exp_t sb_e;
  logic [2:0] prev_state = 3'd0;

  round_sequencer #(
    .COUNT_TICKS(20), .KO_TICKS(40), .HOLD_TICKS(40), .ROUNDS_TO_WIN(2), .TIME_LIMIT(TL)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .winner(winner),
    .health_1(health_1), .health_2(health_2),
    .restart_btn(restart_btn), .force_rst(force_rst),
    .game_rst(game_rst), .play_en(play_en), .state(state), .countdown(countdown),
    .p1_rounds(p1_rounds), .p2_rounds(p2_rounds),
    .match_winner(match_winner), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  initial forever begin
    repeat (3) @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // KO-entry monitor: pops the score expected when the round was decided
  always @(negedge clk) begin
    if (state == 3'd3 && prev_state != 3'd3) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL ko_unexpected: KO entered with p1=%0d p2=%0d, none expected", p1_rounds, p2_rounds);
      end else begin
        sb_e = sb.pop_front();
        if (p1_rounds !== sb_e.p1 || p2_rounds !== sb_e.p2 || timed_out !== sb_e.to) begin
          failures++;
          $display("FAIL ko_score: got p1=%0d p2=%0d to=%0d, expected p1=%0d p2=%0d to=%0d",
                   p1_rounds, p2_rounds, timed_out, sb_e.p1, sb_e.p2, sb_e.to);
        end
      end
    end
    prev_state = state;
  end

  task automatic wait_tick();
    @(posedge clk iff tick);
    #2;
  endtask

  task automatic run_to_fight();
    repeat (61) wait_tick();
    checks++;
    if (state !== 3'd2 || play_en !== 1'b1) begin
      failures++;
      $display("FAIL fight_entry: state=%0d play_en=%0d, expected state=2 play_en=1", state, play_en);
    end
  endtask

  task automatic win_round(input logic [1:0] code, input logic [1:0] ep1, input logic [1:0] ep2);
    winner = code;
    sb.push_back('{p1: ep1, p2: ep2, to: 1'b0});
    wait_tick();
    winner = 2'b00;
    checks++;
    if (state !== 3'd3 || play_en !== 1'b0) begin
      failures++;
      $display("FAIL ko_entry: state=%0d play_en=%0d, expected state=3 play_en=0", state, play_en);
    end
  endtask

  task automatic ko_wait(input logic [2:0] next_state);
    repeat (39) wait_tick();
    checks++;
    if (state !== 3'd3) begin
      failures++;
      $display("FAIL ko_hold: state=%0d after 39 KO ticks, expected 3", state);
    end
    wait_tick();
    checks++;
    if (state !== next_state) begin
      failures++;
      $display("FAIL ko_exit: state=%0d after 40 KO ticks, expected %0d", state, next_state);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (state !== 3'd0 || game_rst !== 1'b1 || play_en !== 1'b0 || countdown !== 2'd0) begin
      failures++;
      $display("FAIL reset_ctrl: state=%0d game_rst=%0d play_en=%0d countdown=%0d, expected 0 1 0 0",
               state, game_rst, play_en, countdown);
    end
    checks++;
    if (p1_rounds !== 2'd0 || p2_rounds !== 2'd0 || match_winner !== 2'd0 || timed_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_score: p1=%0d p2=%0d mw=%0d to=%0d, expected all 0",
               p1_rounds, p2_rounds, match_winner, timed_out);
    end
    reset = 1'b1;
  endtask

  task automatic test_countdown();
    logic [1:0] exp_d;
    wait_tick();
    checks++;
    if (state !== 3'd1 || countdown !== 2'd3 || game_rst !== 1'b0) begin
      failures++;
      $display("FAIL cd_start: state=%0d countdown=%0d game_rst=%0d, expected 1 3 0", state, countdown, game_rst);
    end
    for (int k = 2; k <= 60; k++) begin
      wait_tick();
      if (k == 20 || k == 21 || k == 40 || k == 41 || k == 60) begin
        exp_d = (k <= 20) ? 2'd3 : (k <= 40) ? 2'd2 : 2'd1;
        checks++;
        if (countdown !== exp_d || play_en !== 1'b0) begin
          failures++;
          $display("FAIL cd_digit: tick %0d countdown=%0d play_en=%0d, expected %0d 0", k, countdown, play_en, exp_d);
        end
      end
    end
    wait_tick();
    checks++;
    if (state !== 3'd2 || play_en !== 1'b1 || countdown !== 2'd0) begin
      failures++;
      $display("FAIL cd_fight: tick 61 state=%0d play_en=%0d countdown=%0d, expected 2 1 0", state, play_en, countdown);
    end
  endtask

  task automatic test_ko();
    win_round(2'b01, 2'd1, 2'd0);
    ko_wait(3'd0);
    checks++;
    if (game_rst !== 1'b1) begin
      failures++;
      $display("FAIL ko_rerst: game_rst=%0d, expected 1", game_rst);
    end
  endtask

  task automatic test_match();
    run_to_fight();
    win_round(2'b01, 2'd2, 2'd0);
    ko_wait(3'd4);
    checks++;
    if (match_winner !== 2'b01) begin
      failures++;
      $display("FAIL match_p1: match_winner=%0d, expected 1", match_winner);
    end
    restart_btn = 1'b1;
    repeat (39) wait_tick();
    restart_btn = 1'b0;
    wait_tick();
    checks++;
    if (state !== 3'd4 || p1_rounds !== 2'd2) begin
      failures++;
      $display("FAIL restart_39: state=%0d p1=%0d, expected 4 2", state, p1_rounds);
    end
    restart_btn = 1'b1;
    repeat (39) wait_tick();
    checks++;
    if (state !== 3'd4) begin
      failures++;
      $display("FAIL restart_early: state=%0d, expected 4", state);
    end
    wait_tick();
    restart_btn = 1'b0;
    checks++;
    if (state !== 3'd0 || p1_rounds !== 2'd0 || p2_rounds !== 2'd0 || match_winner !== 2'd0) begin
      failures++;
      $display("FAIL restart_40: state=%0d p1=%0d p2=%0d mw=%0d, expected all 0",
               state, p1_rounds, p2_rounds, match_winner);
    end
  endtask

  task automatic test_draw();
    run_to_fight();
    win_round(2'b01, 2'd1, 2'd0);
    ko_wait(3'd0);
    run_to_fight();
    win_round(2'b10, 2'd1, 2'd1);
    ko_wait(3'd0);
    run_to_fight();
    win_round(2'b11, 2'd2, 2'd2);
    ko_wait(3'd4);
    checks++;
    if (match_winner !== 2'b11) begin
      failures++;
      $display("FAIL match_draw: match_winner=%0d, expected 3", match_winner);
    end
    force_rst = 1'b1;
    repeat (40) wait_tick();
    force_rst = 1'b0;
    checks++;
    if (state !== 3'd0 || p1_rounds !== 2'd0 || p2_rounds !== 2'd0 || match_winner !== 2'd0) begin
      failures++;
      $display("FAIL force_match: state=%0d p1=%0d p2=%0d mw=%0d, expected all 0",
               state, p1_rounds, p2_rounds, match_winner);
    end
  endtask

  task automatic test_ignore_force();
    wait_tick();
    winner = 2'b10;
    repeat (30) wait_tick();
    checks++;
    if (state !== 3'd1 || p2_rounds !== 2'd0) begin
      failures++;
      $display("FAIL stale_winner: state=%0d p2=%0d, expected 1 0", state, p2_rounds);
    end
    winner = 2'b00;
    repeat (29) wait_tick();
    run_to_fight_tail();
    win_round(2'b01, 2'd1, 2'd0);
    ko_wait(3'd0);
`ifndef ROUND_SEQ_TIMEOUT_EN
    run_to_fight();
    restart_btn = 1'b1;
    repeat (45) wait_tick();
    restart_btn = 1'b0;
    checks++;
    if (state !== 3'd2) begin
      failures++;
      $display("FAIL btn_in_fight: state=%0d, expected 2", state);
    end
    force_rst = 1'b1;
    repeat (39) wait_tick();
    force_rst = 1'b0;
    wait_tick();
    checks++;
    if (state !== 3'd2 || p1_rounds !== 2'd1) begin
      failures++;
      $display("FAIL force_39: state=%0d p1=%0d, expected 2 1", state, p1_rounds);
    end
`else
    wait_tick();
`endif
    force_rst = 1'b1;
    repeat (40) wait_tick();
    force_rst = 1'b0;
    checks++;
    if (state !== 3'd0 || p1_rounds !== 2'd0 || play_en !== 1'b0) begin
      failures++;
      $display("FAIL force_40: state=%0d p1=%0d play_en=%0d, expected 0 0 0", state, p1_rounds, play_en);
    end
  endtask

  // last countdown tick into FIGHT, checked like run_to_fight
  task automatic run_to_fight_tail();
    wait_tick();
    checks++;
    if (state !== 3'd2 || p2_rounds !== 2'd0) begin
      failures++;
      $display("FAIL fight_after_stale: state=%0d p2=%0d, expected 2 0", state, p2_rounds);
    end
  endtask

`ifdef ROUND_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    run_to_fight();
    repeat (9) wait_tick();
    checks++;
    if (state !== 3'd2) begin
      failures++;
      $display("FAIL timeout_early: state=%0d, expected 2", state);
    end
    sb.push_back('{p1: 2'd1, p2: 2'd0, to: 1'b1});
    wait_tick();
    checks++;
    if (state !== 3'd3 || timed_out !== 1'b1) begin
      failures++;
      $display("FAIL timeout_ko: state=%0d timed_out=%0d, expected 3 1", state, timed_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_countdown();
    test_ko();
    test_match();
    test_draw();
    test_ignore_force();
`ifdef ROUND_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d expected KO entries never seen, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Match-flow controller for the fighting game. It owns the round lifecycle: it pulses the physics and health reset, runs a 3-2-1 countdown, gates player input during non-fight phases, latches round wins from the health manager's winner code and declares a best-of-N match winner. It also owns the hold-to-restart logic. Runs in the `clk` domain and advances only on the 20 Hz game-tick enable. It replaces the ad-hoc reset timer in the top level.

## Interface
- `COUNT_TICKS`, 20: ticks per countdown digit (1 s at 20 Hz).
- `KO_TICKS`, 40: ticks the round-end display holds before the next round.
- `HOLD_TICKS`, 40: consecutive ticks restart must be held.
- `ROUNDS_TO_WIN`, 2: round wins needed for the match (range 1–3).
- `TIME_LIMIT`, 1980: fight ticks before timeout (99 s); used only under the macro.

- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: synchronous, active-low.
- `tick` in 1: one-`clk`-wide game-tick enable.
- `winner` in 2: from the health manager; 00 none, 01 P1, 10 P2, 11 draw.
- `health_1`, `health_2` in 9 each: current HP, used only for timeout.
- `restart_btn` in 1: centre button, already synchronised.
- `force_rst` in 1: switch; a held request restarts from any state.
- `game_rst` out 1: reset level for physics, health and collision.
- `play_en` out 1: player inputs and attacks enabled.
- `state` out 3: current state encoding, for menu and 7-seg.
- `countdown` out 2: digit 3..1 in COUNTDOWN, 0 otherwise.
- `p1_rounds`, `p2_rounds` out 2 each: round wins.
- `match_winner` out 2: same coding as `winner`; valid in MATCH_OVER, else 00.
- `timed_out` out 1: last round ended by timeout.

## Operation
- States:
  - RST_RND: `game_rst`=1 for exactly one tick, then go to COUNTDOWN with digit 3.
  - COUNTDOWN: digit decrements every `COUNT_TICKS`. After digit 1 expires, go to FIGHT. `play_en`=0.
  - FIGHT: `play_en`=1. On `winner`≠00, latch the code and go to KO.
  - KO: `play_en`=0. Score was already updated on entry. After `KO_TICKS`:
    - if either score ≥ `ROUNDS_TO_WIN`, go to MATCH_OVER;
    - else go to RST_RND.
  - MATCH_OVER: `match_winner` holds the winner. Leaves only via restart.
- Scoring on entry to KO:
  - 01 increments P1; 10 increments P2.
  - 11 (draw) increments both.
  - Counters saturate at 3.
  - Simultaneous reach of `ROUNDS_TO_WIN` gives `match_winner`=11.
- Restart:
  - `restart_btn` high in MATCH_OVER for `HOLD_TICKS` consecutive ticks, or `force_rst` high for `HOLD_TICKS` consecutive ticks in any state.
  - Effect: clear scores, `match_winner`, `timed_out`; go to RST_RND.
  - Any low sample clears the hold count.
  - `restart_btn` outside MATCH_OVER is ignored, because it doubles as attack.
- `winner` is ignored outside FIGHT, including a stale nonzero value during RST_RND/COUNTDOWN.

## Timing
- All registers update on `posedge clk`.
- State, counters and hold timers advance only when `tick`=1. With `tick`=0 everything holds.
- Outputs are registered and valid the cycle after the qualifying tick edge.
- Latency:
  - RST_RND→FIGHT is 1 + 3·`COUNT_TICKS` ticks.
  - FIGHT→KO is 1 tick after `winner` becomes nonzero.
- Reset (`reset`=0 at an edge) forces, regardless of `tick`:
  - state RST_RND, `game_rst`=1, `play_en`=0, `countdown`=0;
  - scores 0, `match_winner`=00, `timed_out`=0, hold counts 0.
- Reset mid-round discards the round; no score change.

## Configuration
- `ROUND_SEQ_TIMEOUT_EN` defined:
  - A FIGHT tick counter runs.
  - At `TIME_LIMIT` with `winner`=00, the higher of `health_1`/`health_2` wins the round; equal health is a draw (11). `timed_out`=1.
  - `winner`≠00 on the same tick takes priority and gives `timed_out`=0.
- Macro undefined:
  - No counter is built; FIGHT is unbounded.
  - `timed_out` is tied to 0; `health_*` are unused.

## Structure
- Package `round_seq_pkg`: state encodings (RST_RND=0, COUNTDOWN=1, FIGHT=2, KO=3, MATCH_OVER=4), winner codes (NONE, P1, P2, DRAW), score saturation constant.
- Sub-module `hold_timer`: tick-qualified consecutive-high counter, parameter `HOLD_TICKS`, one-tick `fire` pulse. Instantiated twice, for restart and force.

## Test plan
- Release reset, `tick` every 4 clk. Required:
  - `game_rst`=1 for 1 tick;
  - `countdown` reads 3, 2, 1 at 20 ticks each;
  - FIGHT with `play_en`=1 at tick 61.
- In FIGHT drive `winner`=01. Required: KO next tick, `p1_rounds`=1, `play_en`=0; after 40 ticks back to RST_RND.
- P1 wins two rounds. Required: MATCH_OVER, `match_winner`=01. `restart_btn` held 39 ticks then released: no restart. Held 40 ticks: scores 0, RST_RND.
- `winner`=11 at a 1–1 score. Required: both scores 2, `match_winner`=11.
- `winner`=10 during COUNTDOWN: ignored. `force_rst` held 40 ticks mid-FIGHT: RST_RND, scores cleared.
- `ROUND_SEQ_TIMEOUT_EN`, `TIME_LIMIT`=10, health 100 vs 80. Required: P1 wins the round, `timed_out`=1.
